// File: rtl/decode_stage_pkg.sv
// Shared RV32I decode types: opcodes, instruction formats, ALU/compare ops
// and the registered decode bundle handed from decode to execute.
package decode_stage_pkg;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [6:0] {
    OPC_LOAD     = 7'b0000011,
    OPC_MISC_MEM = 7'b0001111,
    OPC_OP_IMM   = 7'b0010011,
    OPC_AUIPC    = 7'b0010111,
    OPC_STORE    = 7'b0100011,
    OPC_OP       = 7'b0110011,
    OPC_LUI      = 7'b0110111,
    OPC_BRANCH   = 7'b1100011,
    OPC_JALR     = 7'b1100111,
    OPC_JAL      = 7'b1101111,
    OPC_SYSTEM   = 7'b1110011
  } opcode_t;

  typedef enum logic [2:0] {
    R_TYPE = 3'd0,
    I_TYPE = 3'd1,
    S_TYPE = 3'd2,
    B_TYPE = 3'd3,
    U_TYPE = 3'd4,
    J_TYPE = 3'd5
  } inst_format_t;

  // Encoded as {funct7[5], funct3} so OP/OP_IMM map straight through.
  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SLL  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_OR   = 4'b0110,
    ALU_AND  = 4'b0111,
    ALU_SUB  = 4'b1000,
    ALU_SRA  = 4'b1101
  } alu_op_t;

  typedef enum logic [2:0] {
    CMP_BEQ  = 3'b000,
    CMP_BNE  = 3'b001,
    CMP_BLT  = 3'b100,
    CMP_BGE  = 3'b101,
    CMP_BLTU = 3'b110,
    CMP_BGEU = 3'b111
  } cmp_op_t;

  typedef struct packed {
    logic [31:0]  pc;
    opcode_t      opcode;
    inst_format_t format;
    alu_op_t      alu_op;
    cmp_op_t      cmp_op;
    logic [4:0]   rs1;
    logic [4:0]   rs2;
    logic [4:0]   rd;
    logic         rd_we;
    logic [31:0]  imm;
    logic         illegal;
  } decode_bundle_t;

  function automatic logic is_known_opcode(input logic [6:0] opc);
    case (opc)
      OPC_LOAD, OPC_MISC_MEM, OPC_OP_IMM, OPC_AUIPC, OPC_STORE, OPC_OP,
      OPC_LUI, OPC_BRANCH, OPC_JALR, OPC_JAL, OPC_SYSTEM: is_known_opcode = 1'b1;
      default: is_known_opcode = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational immediate generator; every format sign-extends instr[31].
// Also used by the fetch-side branch predictor.
module imm_gen
  import decode_stage_pkg::*;
(
  input  logic [31:0]  instr,
  input  inst_format_t format,
  output logic [31:0]  imm
);

  always_comb begin
    imm = 32'd0;
    case (format)
      I_TYPE: imm = {{20{instr[31]}}, instr[31:20]};
      S_TYPE: imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      B_TYPE: imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      U_TYPE: imm = {instr[31:12], 12'd0};
      J_TYPE: imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = 32'd0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: decodes a fetched {pc, instr} and holds the result in a
// single registered slot with valid/ready backpressure and branch flush.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int               XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [31:0]     in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [6:0]      out_opcode,
  output logic [2:0]      out_format,
  output logic [3:0]      out_alu_op,
  output logic [2:0]      out_cmp_op,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic            out_rd_we,
  output logic [31:0]     out_imm,
  output logic            out_illegal
);

  localparam decode_bundle_t RESET_BUNDLE = '{
    pc:      RESET_PC,
    opcode:  opcode_t'(7'd0),
    format:  R_TYPE,
    alu_op:  ALU_ADD,
    cmp_op:  CMP_BEQ,
    rs1:     5'd0,
    rs2:     5'd0,
    rd:      5'd0,
    rd_we:   1'b0,
    imm:     32'd0,
    illegal: 1'b0
  };

  logic [6:0]     opc;
  logic [2:0]     f3;
  logic [6:0]     f7;
  inst_format_t   fmt;
  alu_op_t        alu_op;
  cmp_op_t        cmp_op;
  logic           illegal;
  logic [31:0]    imm;
  logic           f7_std;
  logic           take;
  logic           valid_reg;
  logic           valid_next;
  decode_bundle_t bundle_reg;
  decode_bundle_t bundle_next;

  assign opc    = in_instr[6:0];
  assign f3     = in_instr[14:12];
  assign f7     = in_instr[31:25];
  assign f7_std = (f7 == F7_BASE) || (f7 == F7_ALT);

  always_comb begin
    fmt     = R_TYPE;
    alu_op  = ALU_ADD;
    cmp_op  = CMP_BEQ;
    illegal = (in_instr[1:0] != 2'b11) || !is_known_opcode(opc);
    case (opc)
      OPC_OP: begin
        fmt    = R_TYPE;
        alu_op = alu_op_t'({f7[5], f3});
        if (!f7_std) illegal = 1'b1;
        if (f7 == F7_ALT && f3 != 3'b000 && f3 != 3'b101) illegal = 1'b1;
      end
      OPC_OP_IMM: begin
        fmt    = I_TYPE;
        alu_op = alu_op_t'({(f3 == 3'b101) ? f7[5] : 1'b0, f3});
        // Shift-immediates reuse funct7 as an opcode extension.
        if ((f3 == 3'b001 || f3 == 3'b101) && !f7_std) illegal = 1'b1;
        if (f3 == 3'b001 && f7 == F7_ALT) illegal = 1'b1;
      end
      OPC_LOAD: begin
        fmt = I_TYPE;
        if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) illegal = 1'b1;
      end
      OPC_STORE: begin
        fmt = S_TYPE;
        if (f3 > 3'b010) illegal = 1'b1;
      end
      OPC_BRANCH: begin
        fmt    = B_TYPE;
        cmp_op = cmp_op_t'(f3);
        if (f3 == 3'b010 || f3 == 3'b011) illegal = 1'b1;
      end
      OPC_JALR: begin
        fmt = I_TYPE;
        if (f3 != 3'b000) illegal = 1'b1;
      end
      OPC_MISC_MEM: fmt = I_TYPE;
      OPC_SYSTEM: begin
        fmt = I_TYPE;
        if (f3 != 3'b000) illegal = 1'b1;
      end
      OPC_LUI, OPC_AUIPC: fmt = U_TYPE;
      OPC_JAL:            fmt = J_TYPE;
      default: fmt = R_TYPE;
    endcase
  end

  imm_gen u_imm_gen (
    .instr  (in_instr),
    .format (fmt),
    .imm    (imm)
  );

  always_comb begin
    bundle_next         = RESET_BUNDLE;
    bundle_next.pc      = in_pc;
    bundle_next.opcode  = opcode_t'(opc);
    bundle_next.format  = fmt;
    bundle_next.alu_op  = alu_op;
    bundle_next.cmp_op  = cmp_op;
    bundle_next.rs1     = (fmt == U_TYPE || fmt == J_TYPE) ? 5'd0 : in_instr[19:15];
    bundle_next.rs2     = (fmt == R_TYPE || fmt == S_TYPE || fmt == B_TYPE) ? in_instr[24:20] : 5'd0;
    bundle_next.rd      = in_instr[11:7];
    bundle_next.rd_we   = (in_instr[11:7] != 5'd0) && !illegal
                        && (fmt == R_TYPE || fmt == I_TYPE || fmt == U_TYPE || fmt == J_TYPE)
                        && (opc != OPC_MISC_MEM) && (opc != OPC_SYSTEM);
    bundle_next.imm     = imm;
    bundle_next.illegal = illegal;
  end

  // Flush wins over everything: nothing is accepted and the slot empties.
  assign in_ready = !flush && (!valid_reg || out_ready);
  assign take     = in_valid && in_ready;

  always_comb begin
    valid_next = valid_reg;
    if (flush)          valid_next = 1'b0;
    else if (take)      valid_next = 1'b1;
    else if (out_ready) valid_next = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg  <= 1'b0;
      bundle_reg <= RESET_BUNDLE;
    end else begin
      valid_reg <= valid_next;
      if (take) bundle_reg <= bundle_next;
    end
  end

  assign out_valid   = valid_reg;
  assign out_pc      = bundle_reg.pc;
  assign out_opcode  = bundle_reg.opcode;
  assign out_format  = bundle_reg.format;
  assign out_alu_op  = bundle_reg.alu_op;
  assign out_cmp_op  = bundle_reg.cmp_op;
  assign out_rs1     = bundle_reg.rs1;
  assign out_rs2     = bundle_reg.rs2;
  assign out_rd      = bundle_reg.rd;
  assign out_rd_we   = bundle_reg.rd_we;
  assign out_imm     = bundle_reg.imm;
  assign out_illegal = bundle_reg.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: a table of hand-decoded instructions plus
// backpressure, flush and mid-stall reset sequences.
module tb_decode_stage;

  localparam logic [31:0] RST_PC = 32'h0000_1000;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [6:0]  out_opcode;
  logic [2:0]  out_format;
  logic [3:0]  out_alu_op;
  logic [2:0]  out_cmp_op;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic [4:0]  out_rd;
  logic        out_rd_we;
  logic [31:0] out_imm;
  logic        out_illegal;

  int n_vec;
  int n_err;

  decode_stage #(.XLEN(32), .RESET_PC(RST_PC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_pc       (in_pc),
    .in_instr    (in_instr),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_opcode  (out_opcode),
    .out_format  (out_format),
    .out_alu_op  (out_alu_op),
    .out_cmp_op  (out_cmp_op),
    .out_rs1     (out_rs1),
    .out_rs2     (out_rs2),
    .out_rd      (out_rd),
    .out_rd_we   (out_rd_we),
    .out_imm     (out_imm),
    .out_illegal (out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [2:0]  fmt;
    logic [3:0]  alu;
    logic [2:0]  cmp;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rd_we;
    logic [31:0] imm;
    logic        ill;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    rst_n     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_pc     = 32'd0;
    in_instr  = 32'd0;
    out_ready = 1'b1;

    // name, pc, instr, opcode, fmt, alu, cmp, rs1, rs2, rd, rd_we, imm, illegal
    vecs[0]  = '{"addi",    32'h100, 32'h00500093, 7'h13, 3'd1, 4'h0, 3'd0, 5'd0,  5'd0,  5'd1,  1'b1, 32'h00000005, 1'b0};
    vecs[1]  = '{"sub",     32'h104, 32'h402081B3, 7'h33, 3'd0, 4'h8, 3'd0, 5'd1,  5'd2,  5'd3,  1'b1, 32'h00000000, 1'b0};
    vecs[2]  = '{"srai",    32'h108, 32'h4032D293, 7'h13, 3'd1, 4'hD, 3'd0, 5'd5,  5'd0,  5'd5,  1'b1, 32'h00000403, 1'b0};
    vecs[3]  = '{"bne",     32'h10C, 32'hFE209EE3, 7'h63, 3'd3, 4'h0, 3'd1, 5'd1,  5'd2,  5'd29, 1'b0, 32'hFFFFFFFC, 1'b0};
    vecs[4]  = '{"lui",     32'h110, 32'h123453B7, 7'h37, 3'd4, 4'h0, 3'd0, 5'd0,  5'd0,  5'd7,  1'b1, 32'h12345000, 1'b0};
    vecs[5]  = '{"sw",      32'h114, 32'h0020A423, 7'h23, 3'd2, 4'h0, 3'd0, 5'd1,  5'd2,  5'd8,  1'b0, 32'h00000008, 1'b0};
    vecs[6]  = '{"jal",     32'h118, 32'h008000EF, 7'h6F, 3'd5, 4'h0, 3'd0, 5'd0,  5'd0,  5'd1,  1'b1, 32'h00000008, 1'b0};
    vecs[7]  = '{"ecall",   32'h11C, 32'h00000073, 7'h73, 3'd1, 4'h0, 3'd0, 5'd0,  5'd0,  5'd0,  1'b0, 32'h00000000, 1'b0};
    vecs[8]  = '{"ld_bad",  32'h120, 32'h0000B083, 7'h03, 3'd1, 4'h0, 3'd0, 5'd1,  5'd0,  5'd1,  1'b0, 32'h00000000, 1'b1};
    vecs[9]  = '{"all1",    32'h124, 32'hFFFFFFFF, 7'h7F, 3'd0, 4'h0, 3'd0, 5'd31, 5'd31, 5'd31, 1'b0, 32'h00000000, 1'b1};
    vecs[10] = '{"opc7f",   32'h128, 32'h0000007F, 7'h7F, 3'd0, 4'h0, 3'd0, 5'd0,  5'd0,  5'd0,  1'b0, 32'h00000000, 1'b1};

    // Reset state
    #2 rst_n = 1'b0;
    step();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_pc",    out_pc, RST_PC);
    check("rst_format",    {29'd0, out_format}, 32'd0);
    check("rst_alu_op",    {28'd0, out_alu_op}, 32'd0);
    check("rst_imm",       out_imm, 32'd0);
    check("rst_rd_we",     {31'd0, out_rd_we}, 32'd0);
    rst_n = 1'b1;
    step();
    check("rst_in_ready",  {31'd0, in_ready}, 32'd1);

    // Decode table, one instruction per cycle with execute always ready
    for (int i = 0; i < 11; i++) begin
      in_valid = 1'b1;
      in_pc    = vecs[i].pc;
      in_instr = vecs[i].instr;
      step();
      in_valid = 1'b0;
      check({vecs[i].name, ".valid"},   {31'd0, out_valid}, 32'd1);
      check({vecs[i].name, ".pc"},      out_pc, vecs[i].pc);
      check({vecs[i].name, ".opcode"},  {25'd0, out_opcode}, {25'd0, vecs[i].opcode});
      check({vecs[i].name, ".format"},  {29'd0, out_format}, {29'd0, vecs[i].fmt});
      check({vecs[i].name, ".alu_op"},  {28'd0, out_alu_op}, {28'd0, vecs[i].alu});
      check({vecs[i].name, ".cmp_op"},  {29'd0, out_cmp_op}, {29'd0, vecs[i].cmp});
      check({vecs[i].name, ".rs1"},     {27'd0, out_rs1}, {27'd0, vecs[i].rs1});
      check({vecs[i].name, ".rs2"},     {27'd0, out_rs2}, {27'd0, vecs[i].rs2});
      check({vecs[i].name, ".rd"},      {27'd0, out_rd}, {27'd0, vecs[i].rd});
      check({vecs[i].name, ".rd_we"},   {31'd0, out_rd_we}, {31'd0, vecs[i].rd_we});
      check({vecs[i].name, ".imm"},     out_imm, vecs[i].imm);
      check({vecs[i].name, ".illegal"}, {31'd0, out_illegal}, {31'd0, vecs[i].ill});
      $display("vector %0d %s instr=%h pc=%h", i, vecs[i].name, vecs[i].instr, vecs[i].pc);
    end
    step();
    check("drain_valid", {31'd0, out_valid}, 32'd0);

    // Backpressure: A held, B stalled, then B delivered exactly once
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_pc     = 32'h200;
    in_instr  = 32'h00500093;
    step();
    check("bp_a_valid", {31'd0, out_valid}, 32'd1);
    check("bp_a_pc",    out_pc, 32'h200);
    in_pc    = 32'h204;
    in_instr = 32'h402081B3;
    check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    step();
    check("bp_a_hold_pc",   out_pc, 32'h200);
    check("bp_a_hold_imm",  out_imm, 32'h5);
    check("bp_a_hold_fmt",  {29'd0, out_format}, 32'd1);
    check("bp_in_ready_low2", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check("bp_b_valid",  {31'd0, out_valid}, 32'd1);
    check("bp_b_pc",     out_pc, 32'h204);
    check("bp_b_alu",    {28'd0, out_alu_op}, 32'h8);
    step();
    check("bp_no_dup",   {31'd0, out_valid}, 32'd0);
    $display("sequence backpressure done");

    // Flush with a held bundle and a pending input
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_pc     = 32'h300;
    in_instr  = 32'h123453B7;
    step();
    check("fl_a_valid", {31'd0, out_valid}, 32'd1);
    in_pc     = 32'h304;
    in_instr  = 32'hFE209EE3;
    out_ready = 1'b1;
    flush     = 1'b1;
    check("fl_in_ready", {31'd0, in_ready}, 32'd0);
    step();
    flush = 1'b0;
    check("fl_valid_cleared", {31'd0, out_valid}, 32'd0);
    check("fl_not_consumed",  out_pc, 32'h300);
    step();
    in_valid = 1'b0;
    check("fl_refetch_valid", {31'd0, out_valid}, 32'd1);
    check("fl_refetch_pc",    out_pc, 32'h304);
    check("fl_refetch_fmt",   {29'd0, out_format}, 32'd3);
    step();
    $display("sequence flush done");

    // Asynchronous reset in the middle of a stall
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_pc     = 32'h400;
    in_instr  = 32'h00500093;
    step();
    in_valid = 1'b0;
    check("rs_held_valid", {31'd0, out_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rs_valid_now", {31'd0, out_valid}, 32'd0);
    check("rs_pc_now",    out_pc, RST_PC);
    step();
    rst_n = 1'b1;
    step();
    check("rs_in_ready",  {31'd0, in_ready}, 32'd1);
    $display("sequence mid-stall reset done");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- RV32I decode pipeline stage between instruction fetch and execute.
- Accepts a fetched {pc, instr} over a valid/ready handshake.
- Decodes it into the shared types (opcode_t, inst_format_t, alu_op_t, cmp_op_t), generates the sign-extended immediate, flags illegal encodings, and holds the result in a registered output slot with backpressure and flush.

Parameters:
- XLEN, 32, datapath and PC width; only 32 is supported.
- RESET_PC, 32'h0000_0000, reset value of out_pc.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous kill of the held and incoming instruction (branch redirect)
- in_valid  in  1  fetch has an instruction
- in_ready  out  1  stage can accept this cycle
- in_pc  in  XLEN  PC of the instruction
- in_instr  in  32  raw instruction word
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  execute accepts the bundle
- out_pc  out  XLEN  registered PC
- out_opcode  out  7  opcode_t
- out_format  out  3  inst_format_t
- out_alu_op  out  4  alu_op_t
- out_cmp_op  out  3  cmp_op_t; meaningful for BRANCH only
- out_rs1  out  5  source register 1; 0 when unused
- out_rs2  out  5  source register 2; 0 when unused
- out_rd  out  5  destination register
- out_rd_we  out  1  register write enable
- out_imm  out  32  sign-extended immediate; 0 for R_TYPE
- out_illegal  out  1  illegal or unsupported encoding

Behaviour:
- Reset (rst_n=0, asynchronous):
  - out_valid=0.
  - All data outputs 0, except out_pc=RESET_PC.
  - out_format=R_TYPE, out_alu_op=ALU_ADD, out_cmp_op=CMP_BEQ.
- Handshake:
  - in_ready = !flush && (!out_valid || out_ready), combinational.
  - A transfer occurs when in_valid && in_ready; the bundle is captured at that edge, so latency is 1 cycle.
  - If out_valid && out_ready && no new transfer, out_valid clears the next cycle.
  - While out_valid && !out_ready, all out_* hold stable.
- flush:
  - Highest priority: next cycle out_valid=0 and the input is not consumed.
  - Data registers may keep stale values.
- Format by opcode:
  - OP → R.
  - OP_IMM, LOAD, JALR, MISC_MEM, SYSTEM → I.
  - STORE → S; BRANCH → B; LUI, AUIPC → U; JAL → J.
- alu_op:
  - OP: {f7[5], f3}.
  - OP_IMM: {f3==101 ? f7[5] : 0, f3}.
  - All others: ALU_ADD.
- cmp_op = f3 for BRANCH.
- Immediate formats (all immediates sign-extend bit 31):
  - I: instr[31:20]
  - S: {[31:25],[11:7]}
  - B: {[31],[7],[30:25],[11:8],0}
  - U: {[31:12],12'b0}
  - J: {[31],[19:12],[20],[30:21],0}
- Register fields:
  - rs1 forced 0 for U/J.
  - rs2 forced 0 for I/U/J.
- out_rd_we = (rd!=0) && format in {R,I,U,J} && opcode not MISC_MEM/SYSTEM && !illegal.
- Illegal when any of:
  - instr[1:0]!=11, or opcode not in opcode_t.
  - OP with f7 ∉ {0000000, 0100000}, or f7=0100000 with f3 ∉ {000, 101}.
  - OP_IMM shift (f3=001/101) with f7 ∉ {0000000, 0100000}, or f3=001 with f7=0100000.
  - LOAD with f3 ∈ {011, 110, 111}.
  - STORE with f3 > 010.
  - BRANCH with f3 ∈ {010, 011}.
  - JALR with f3 != 000.
  - SYSTEM with f3 != 000 (no Zicsr).
- Illegal instructions still propagate with out_illegal=1, out_rd_we=0; the trap is taken downstream.
- Reset mid-operation: the held bundle is discarded immediately; in_ready=1 after release.

Decomposition:
- Add to package types:
  - decode_bundle_t struct: pc, opcode, format, alu_op, cmp_op, rs1, rs2, rd, rd_we, imm, illegal.
  - Constants F7_BASE=7'b0000000 and F7_ALT=7'b0100000.
- Sub-module imm_gen (combinational: instr + inst_format_t → 32-bit imm), reused by the fetch branch predictor.

Test Plan:
- ADDI x1,x0,5 (0x00500093), pc 0x100, out_ready=1 → next cycle: out_valid=1, I_TYPE, ALU_ADD, imm=5, rd=1, rd_we=1, rs1=0, rs2=0, illegal=0.
- SUB x3,x1,x2 (0x402081B3) → R_TYPE, ALU_SUB, rs1=1, rs2=2, rd=3, imm=0. SRAI x5,x5,3 (0x4032D293) → ALU_SRA, imm=0x403.
- BNE x1,x2,-4 (0xFE209EE3) → B_TYPE, CMP_BNE, imm=0xFFFFFFFC, rd_we=0. LUI x7,0x12345 (0x123453B7) → U_TYPE, imm=0x12345000.
- Backpressure: two back-to-back instructions with out_ready=0 → first held stable, in_ready=0, second not taken. Raise out_ready → second appears one cycle later, with no loss or duplication.
- Flush with out_valid=1 and in_valid=1 → next cycle out_valid=0, input not consumed. Fetch re-presents the instruction → accepted normally.
- 0xFFFFFFFF and 0x0000007F → illegal=1, rd_we=0. Assert rst_n=0 mid-stall → out_valid=0 immediately, out_pc=RESET_PC.
